// File: rtl/gate_op_pkg.sv
// Shared types and constants for the logic-unit operation probe:
// FSM states, operation codes, expected truth patterns and the table decoder.
package gate_op_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DECODE = 2'd2
  } state_e;

  localparam logic [1:0] OP_AND  = 2'd0;
  localparam logic [1:0] OP_NAND = 2'd1;
  localparam logic [1:0] OP_NOR  = 2'd2;
  localparam logic [1:0] OP_OR   = 2'd3;

  // truth bit index is {A,B}
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_OR   = 4'b1110;

  // Returns {valid, sel}; unrecognised tables decode to {0, OP_AND}.
  function automatic logic [2:0] tt_to_sel(input logic [3:0] tt);
    logic [2:0] r;
    r = {1'b0, OP_AND};
    case (tt)
      TT_AND:  r = {1'b1, OP_AND};
      TT_NAND: r = {1'b1, OP_NAND};
      TT_NOR:  r = {1'b1, OP_NOR};
      TT_OR:   r = {1'b1, OP_OR};
      default: r = {1'b0, OP_AND};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_op_identifier.sv
// Probe that walks A/B through 00,01,10,11, captures the unit's response
// into a truth table and decodes it back to the unit's operation select.
module gate_op_identifier
  import gate_op_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       tito,
  output logic       A,
  output logic       B,
  output logic       busy,
  output logic       done,
  output logic [1:0] SEL,
  output logic       valid,
  output logic [3:0] truth
);

  localparam int CW = $clog2(SETTLE + 1);

  generate
    if (SETTLE < 1) begin : g_bad_settle
      $error("gate_op_identifier: SETTLE must be >= 1");
    end
  endgenerate

  state_e          state;
  logic [1:0]      vec;
  logic [CW-1:0]   cnt;
  logic            hold_last;
  logic [1:0]      vec_nxt;
  logic [2:0]      dec;

  assign hold_last = (cnt == CW'(SETTLE - 1));
  assign vec_nxt   = vec + 2'd1;
  assign dec       = tt_to_sel(truth);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      vec   <= '0;
      cnt   <= '0;
      A     <= 1'b0;
      B     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      SEL   <= '0;
      valid <= 1'b0;
      truth <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            truth <= '0;
            vec   <= '0;
            cnt   <= '0;
            A     <= 1'b0;
            B     <= 1'b0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (hold_last) begin
            truth[vec] <= tito;
            cnt        <= '0;
            vec        <= vec_nxt;
            // the last vector stays on A/B until the decode edge
            if (vec == 2'd3) begin
              state <= DECODE;
            end else begin
              A <= vec_nxt[1];
              B <= vec_nxt[0];
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DECODE: begin
          SEL   <= dec[1:0];
          valid <= dec[2];
          done  <= 1'b1;
          busy  <= 1'b0;
          A     <= 1'b0;
          B     <= 1'b0;
          vec   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_op_identifier.sv
// Scoreboard bench: stimulus pushes expected results, negedge monitors pop
// and compare on every done pulse.
module tb_gate_op_identifier;

  typedef struct {
    int         due;
    logic [3:0] truth;
    logic [1:0] sel;
    logic       valid;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start1 = 1'b0, start3 = 1'b0;
  logic tito1, tito3;
  logic A1, B1, busy1, done1, valid1;
  logic A3, B3, busy3, done3, valid3;
  logic [1:0] sel1, sel3;
  logic [3:0] truth1, truth3;

  int op1 = 2;
  bit dly1 = 1'b0;
  logic [1:0] ab1_d1 = 2'b00, ab1_d2 = 2'b00;
  logic [1:0] ab3_d1 = 2'b00, ab3_d2 = 2'b00;

  int cyc = 0;
  int applied = 0;
  int miscompares = 0;
  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;
  logic [1:0] last_sel = 2'd0;
  logic       last_valid = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // logic-unit model; ops 4/5 tie the response low/high
  function automatic logic f(input int op, input logic [1:0] ab);
    case (op)
      0: return ab[1] & ab[0];
      1: return ~(ab[1] & ab[0]);
      2: return ~(ab[1] | ab[0]);
      3: return ab[1] | ab[0];
      4: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  always @(posedge clk) begin
    ab1_d1 <= {A1, B1};
    ab1_d2 <= ab1_d1;
    ab3_d1 <= {A3, B3};
    ab3_d2 <= ab3_d1;
  end

  assign tito1 = f(op1, dly1 ? ab1_d2 : {A1, B1});
  assign tito3 = f(2, ab3_d2);

  gate_op_identifier #(.SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start1), .tito(tito1),
    .A(A1), .B(B1), .busy(busy1), .done(done1),
    .SEL(sel1), .valid(valid1), .truth(truth1)
  );

  gate_op_identifier #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .tito(tito3),
    .A(A3), .B(B3), .busy(busy3), .done(done3),
    .SEL(sel3), .valid(valid3), .truth(truth3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      if (q1.size() == 0) begin
        applied++;
        miscompares++;
        $display("FAIL dut1 unexpected done: got pulse at cycle %0d, expected none", cyc);
      end else begin
        e1 = q1.pop_front();
        chk("dut1 done cycle", cyc, e1.due);
        chk("dut1 truth", truth1, e1.truth);
        chk("dut1 SEL", sel1, e1.sel);
        chk("dut1 valid", valid1, e1.valid);
        chk("dut1 busy at done", busy1, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (done3 === 1'b1) begin
      if (q3.size() == 0) begin
        applied++;
        miscompares++;
        $display("FAIL dut3 unexpected done: got pulse at cycle %0d, expected none", cyc);
      end else begin
        e3 = q3.pop_front();
        chk("dut3 done cycle", cyc, e3.due);
        chk("dut3 truth", truth3, e3.truth);
        chk("dut3 SEL", sel3, e3.sel);
        chk("dut3 valid", valid3, e3.valid);
      end
    end
  end

  task automatic push1(input int due, input logic [3:0] t, input logic [1:0] s, input logic v);
    exp_t x;
    x.due = due; x.truth = t; x.sel = s; x.valid = v;
    q1.push_back(x);
  endtask

  // one SETTLE=1 run: checks the A/B walk and that SEL/valid hold mid-run
  task automatic run1(input int op, input bit dly, input logic [3:0] t,
                      input logic [1:0] s, input logic v);
    op1 = op;
    dly1 = dly;
    @(posedge clk); #1;
    push1(cyc + 6, t, s, v);
    start1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      start1 = 1'b0;
      chk("A/B vector", {A1, B1}, i[1:0]);
      if (i == 2) begin
        chk("SEL hold mid-run", sel1, last_sel);
        chk("valid hold mid-run", valid1, last_valid);
      end
    end
    repeat (4) @(posedge clk);
    #1;
    last_sel = s;
    last_valid = v;
  endtask

  initial begin
    #100000;
    $display("FAIL global timeout: got no finish, expected finish by cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset A", A1, 0);
    chk("reset B", B1, 0);
    chk("reset busy", busy1, 0);
    chk("reset done", done1, 0);
    chk("reset SEL", sel1, 0);
    chk("reset valid", valid1, 0);
    chk("reset truth", truth1, 0);
    chk("reset dut3 busy", busy3, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // NOR first, then the remaining operations
    run1(2, 0, 4'b0001, 2'd2, 1'b1);
    run1(0, 0, 4'b1000, 2'd0, 1'b1);
    run1(1, 0, 4'b0111, 2'd1, 1'b1);
    run1(3, 0, 4'b1110, 2'd3, 1'b1);
    // stuck responses
    run1(4, 0, 4'b0000, 2'd0, 1'b0);
    run1(5, 0, 4'b1111, 2'd0, 1'b0);

    // start held 12 cycles: second accept in the done cycle
    op1 = 3;
    @(posedge clk); #1;
    push1(cyc + 6, 4'b1110, 2'd3, 1'b1);
    push1(cyc + 12, 4'b1110, 2'd3, 1'b1);
    start1 = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // extra starts while busy are dropped
    op1 = 0;
    @(posedge clk); #1;
    push1(cyc + 6, 4'b1000, 2'd0, 1'b1);
    start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    @(posedge clk); #1; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    @(posedge clk); #1; start1 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; start1 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    last_sel = 2'd0;
    last_valid = 1'b1;

    // reset while vector 2 is applied
    op1 = 2;
    @(posedge clk); #1;
    start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("pre-reset vector", {A1, B1}, 2);
    rst_n = 1'b0;
    #1;
    chk("mid-reset A", A1, 0);
    chk("mid-reset B", B1, 0);
    chk("mid-reset busy", busy1, 0);
    chk("mid-reset done", done1, 0);
    chk("mid-reset SEL", sel1, 0);
    chk("mid-reset valid", valid1, 0);
    chk("mid-reset truth", truth1, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    last_sel = 2'd0;
    last_valid = 1'b0;
    run1(2, 0, 4'b0001, 2'd2, 1'b1);

    // response lagging 2 cycles with a 1-cycle hold samples stale vectors
    run1(1, 1, 4'b1111, 2'd0, 1'b0);
    dly1 = 1'b0;

    // same lag, 3-cycle hold: NOR recovered
    @(posedge clk); #1;
    begin
      exp_t x;
      x.due = cyc + 14; x.truth = 4'b0001; x.sel = 2'd2; x.valid = 1'b1;
      q3.push_back(x);
    end
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    chk("dut3 busy", busy3, 1);
    repeat (16) @(posedge clk);
    #1;
    chk("dut3 busy after run", busy3, 0);

    repeat (4) @(posedge clk);
    #1;
    chk("dut1 pending results", q1.size(), 0);
    chk("dut3 pending results", q3.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
